mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the pipeline, between execute and `wb_stage`. Accepts one instruction at a time from execute, performs loads/stores over a request/acknowledge data-memory port with byte enables, aligns and sign/zero-extends load data, and presents the writeback result with a one-cycle write-enable pulse. Stalls execute via `ex_ready` while a memory access is outstanding.

## Interface
- `DATA_W`, 32, data and address width; only 32 is supported.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `ex_valid` in 1: execute presents an instruction.
- `ex_ready` out 1: stage can accept; high only in IDLE.
- `alu_result` in 32: effective address for memory ops, or result for non-memory ops.
- `store_data` in 32: store operand, right-aligned.
- `reg_addr` in 5: destination register.
- `reg_write` in 1: instruction writes a register.
- `mem_read`, `mem_write` in 1 each: load / store. Both high is treated as a load.
- `mem_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `mem_unsigned` in 1: zero-extend loads.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32 (bits [1:0] always 0), `dmem_be` out 4, `dmem_wdata` out 32: memory request.
- `dmem_rdata` in 32, `dmem_ack` in 1: memory response.
- `wb_we` out 1, `wb_reg_data` out 32, `wb_reg_addr` out 5, `wb_reg_write` out 1: drive `wb_stage` `we`/`reg_data`/`reg_addr`/`reg_write`.
- `misalign_exc` out 1: one-cycle misaligned-access pulse.

## Operation
- States: IDLE, WAIT.
- Accept means `ex_valid && ex_ready` at a rising edge.
- Non-memory accept in IDLE: next edge loads `wb_reg_data=alu_result`, `wb_reg_addr`, `wb_reg_write`, and sets `wb_we=1` for one cycle. State stays IDLE.
- Memory accept in IDLE: register the request and go to WAIT.
  - In WAIT, `dmem_req=1` and all dmem outputs are stable until `dmem_ack`.
  - `dmem_addr={addr[31:2],2'b00}`.
- Byte enables and write data:
  - Byte: `be=1<<addr[1:0]`, wdata = byte replicated ×4.
  - Half: `be=addr[1]?1100:0011`, wdata = half replicated ×2.
  - Word: `be=1111`, wdata = `store_data`.
- `dmem_ack` in WAIT: next edge returns to IDLE and pulses `wb_we`.
  - Load: `wb_reg_data` = lane selected by the registered offset, sign-extended or zero-extended per `mem_unsigned`.
  - Store: `wb_reg_write=0`, `wb_reg_data=0`.
- `dmem_ack` outside WAIT is ignored.
- When `wb_we=0`, `wb_*` data outputs hold their last values.
- Reset values (low `reset`, asynchronous): state IDLE; all dmem outputs 0; `wb_we`, `wb_reg_data`, `wb_reg_addr`, `wb_reg_write`, `misalign_exc` all 0.
- Reset mid-WAIT drops `dmem_req` immediately. An ack arriving after reset release is ignored.

## Timing
- Non-memory op: accept edge → `wb_we` high the following cycle. Latency 1, throughput 1/cycle.
- Memory op: `dmem_req` rises the cycle after accept.
  - Ack in that same cycle gives `wb_we` one cycle later: minimum accept-to-writeback latency 2.
  - Each extra wait cycle adds 1.
- `ex_ready` is low from the cycle after a memory accept until the cycle after ack. No new accept is possible on the ack edge.
- `wb_we` is never high for two consecutive cycles from the same instruction.

## Configuration
- `MEM_STAGE_ALIGN_CHECK_EN` defined:
  - Misaligned accesses are half with `addr[0]=1`, or word with `addr[1:0]!=0`.
  - They issue no memory request and stay in IDLE.
  - Next edge pulses `misalign_exc=1` together with `wb_we=1`, `wb_reg_write=0`.
- Undefined: offending low address bits are cleared (half: `[0]`; word: `[1:0]`) and the access proceeds normally. `misalign_exc` is tied 0.

## Structure
- Shared package `ace_pkg`: `MEM_SIZE_B/H/W` encodings, `MS_IDLE/MS_WAIT` state encodings.
- One sub-module, `mem_load_align`: combinational lane select plus sign/zero extension, with inputs rdata, offset, size, unsigned.
- Everything else stays in `mem_stage`.

## Test plan
- Non-memory op, `alu_result=0x1234_5678`, `reg_addr=5`, `reg_write=1`: next cycle `wb_we=1`, `wb_reg_data=0x12345678`, `wb_reg_addr=5`, no `dmem_req`.
- Load byte signed at `0x1003`, `rdata=0x80FF_0011`, ack after 3 wait cycles: `dmem_addr=0x1000`, `be=1000`, `wb_reg_data=0xFFFFFF80`; `ex_ready` low throughout.
- Store half at `0x2002`, `store_data=0xAAAA_BEEF`, same-cycle ack: `be=1100`, `wdata=0xBEEFBEEF`, `dmem_we=1`, `wb_we` pulse with `wb_reg_write=0`.
- Load word at `0x3001`:
  - With macro: no `dmem_req`, `misalign_exc=1` for 1 cycle.
  - Without macro: `dmem_addr=0x3000`, `be=1111`.
- Reset asserted in WAIT, then ack one cycle after release: `dmem_req` falls during reset, all outputs 0, late ack yields no `wb_we`.
- Back-to-back non-memory ops for 4 cycles: 4 consecutive `wb_we` pulses carrying the correct data in order.

Source files
------------

// File: rtl/ace_pkg.sv
// Shared pipeline definitions: memory access size encodings, mem_stage states and
// byte-lane helpers for the data-memory port.
package ace_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_WAIT = 1'b1
    } ms_state_e;

    // The reserved size code 2'b11 behaves as a word access.
    function automatic logic [1:0] mem_norm_size(input logic [1:0] size);
        return (size == 2'b11) ? MEM_SIZE_W : size;
    endfunction

    function automatic logic [3:0] mem_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEM_SIZE_B: return 4'b0001 << off;
            MEM_SIZE_H: return off[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] mem_wdata(input logic [1:0] size, input logic [31:0] sd);
        case (size)
            MEM_SIZE_B: return {4{sd[7:0]}};
            MEM_SIZE_H: return {2{sd[15:0]}};
            default:    return sd;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects the addressed byte/half lane of a memory word and
// sign- or zero-extends it to 32 bits.
module mem_load_align
    import ace_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata_i[{offset_i, 3'b000} +: 8];
        half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            MEM_SIZE_B: data_o = {{24{byte_lane[7] & ~unsigned_i}}, byte_lane};
            MEM_SIZE_H: data_o = {{16{half_lane[15] & ~unsigned_i}}, half_lane};
            default:    data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack data port and
// produces a one-cycle writeback pulse. MEM_STAGE_ALIGN_CHECK_EN enables misalignment traps.
module mem_stage
    import ace_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [4:0]        reg_addr_i,
    input  logic              reg_write_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_unsigned_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    input  logic              dmem_ack_i,
    output logic              wb_we_o,
    output logic [DATA_W-1:0] wb_reg_data_o,
    output logic [4:0]        wb_reg_addr_o,
    output logic              wb_reg_write_o,
    output logic              misalign_exc_o
);

    ms_state_e         state_q, state_d;
    logic              dmem_we_q, dmem_we_d;
    logic [DATA_W-3:0] word_addr_q, word_addr_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        off_q, off_d, size_q, size_d;
    logic              uns_q, uns_d, load_q, load_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic              rd_write_q, rd_write_d;
    logic              wb_we_q, wb_we_d, wb_write_q, wb_write_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [4:0]        wb_addr_q, wb_addr_d;

    logic [1:0]        size_n, off_n;
    logic              is_mem, misalign;
    logic [DATA_W-1:0] load_data;

    assign size_n = mem_norm_size(mem_size_i);
    assign is_mem = mem_read_i | mem_write_i;
    // Clearing sub-size address bits is a no-op for aligned accesses.
    assign off_n  = (size_n == MEM_SIZE_B) ? alu_result_i[1:0] :
                    (size_n == MEM_SIZE_H) ? {alu_result_i[1], 1'b0} : 2'b00;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    logic misalign_q;

    assign misalign = ((size_n == MEM_SIZE_H) && alu_result_i[0]) ||
                      ((size_n == MEM_SIZE_W) && (alu_result_i[1:0] != 2'b00));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) misalign_q <= 1'b0;
        else         misalign_q <= ex_valid_i && ex_ready_o && is_mem && misalign;
    end

    assign misalign_exc_o = misalign_q;
`else
    assign misalign       = 1'b0;
    assign misalign_exc_o = 1'b0;
`endif

    mem_load_align u_load_align (
        .rdata_i    (dmem_rdata_i),
        .offset_i   (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (load_data)
    );

    always_comb begin
        state_d     = state_q;
        dmem_we_d   = dmem_we_q;
        word_addr_d = word_addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        load_d      = load_q;
        rd_addr_d   = rd_addr_q;
        rd_write_d  = rd_write_q;
        wb_we_d     = 1'b0;
        wb_data_d   = wb_data_q;
        wb_addr_d   = wb_addr_q;
        wb_write_d  = wb_write_q;
        case (state_q)
            MS_IDLE: begin
                if (ex_valid_i && is_mem && misalign) begin
                    wb_we_d    = 1'b1;
                    wb_data_d  = '0;
                    wb_addr_d  = reg_addr_i;
                    wb_write_d = 1'b0;
                end else if (ex_valid_i && is_mem) begin
                    state_d     = MS_WAIT;
                    dmem_we_d   = ~mem_read_i;
                    word_addr_d = alu_result_i[DATA_W-1:2];
                    be_d        = mem_be(size_n, off_n);
                    wdata_d     = mem_wdata(size_n, store_data_i);
                    off_d       = off_n;
                    size_d      = size_n;
                    uns_d       = mem_unsigned_i;
                    load_d      = mem_read_i;
                    rd_addr_d   = reg_addr_i;
                    rd_write_d  = reg_write_i;
                end else if (ex_valid_i) begin
                    wb_we_d    = 1'b1;
                    wb_data_d  = alu_result_i;
                    wb_addr_d  = reg_addr_i;
                    wb_write_d = reg_write_i;
                end
            end
            MS_WAIT: begin
                if (dmem_ack_i) begin
                    state_d    = MS_IDLE;
                    wb_we_d    = 1'b1;
                    wb_addr_d  = rd_addr_q;
                    wb_data_d  = load_q ? load_data : '0;
                    wb_write_d = load_q & rd_write_q;
                end
            end
            default: state_d = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= MS_IDLE;
            dmem_we_q   <= 1'b0;
            word_addr_q <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            load_q      <= 1'b0;
            rd_addr_q   <= '0;
            rd_write_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_data_q   <= '0;
            wb_addr_q   <= '0;
            wb_write_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dmem_we_q   <= dmem_we_d;
            word_addr_q <= word_addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            load_q      <= load_d;
            rd_addr_q   <= rd_addr_d;
            rd_write_q  <= rd_write_d;
            wb_we_q     <= wb_we_d;
            wb_data_q   <= wb_data_d;
            wb_addr_q   <= wb_addr_d;
            wb_write_q  <= wb_write_d;
        end
    end

    assign ex_ready_o     = (state_q == MS_IDLE);
    assign dmem_req_o     = (state_q == MS_WAIT);
    assign dmem_we_o      = dmem_we_q;
    assign dmem_addr_o    = {word_addr_q, 2'b00};
    assign dmem_be_o      = be_q;
    assign dmem_wdata_o   = wdata_q;
    assign wb_we_o        = wb_we_q;
    assign wb_reg_data_o  = wb_data_q;
    assign wb_reg_addr_o  = wb_addr_q;
    assign wb_reg_write_o = wb_write_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random loads/stores against a
// byte-addressed memory model. Honours MEM_STAGE_ALIGN_CHECK_EN.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_ready;
    logic [31:0] alu_result = '0, store_data = '0;
    logic [4:0]  reg_addr = '0;
    logic        reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0, mem_unsigned = 1'b0;
    logic [1:0]  mem_size = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        wb_we, wb_reg_write, misalign_exc;
    logic [31:0] wb_reg_data;
    logic [4:0]  wb_reg_addr;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  ref_bytes [256];  // reference model, byte addressed
    logic [31:0] mem_words [64];   // memory seen by the DUT port

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(32)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .ex_valid_i     (ex_valid),
        .ex_ready_o     (ex_ready),
        .alu_result_i   (alu_result),
        .store_data_i   (store_data),
        .reg_addr_i     (reg_addr),
        .reg_write_i    (reg_write),
        .mem_read_i     (mem_read),
        .mem_write_i    (mem_write),
        .mem_size_i     (mem_size),
        .mem_unsigned_i (mem_unsigned),
        .dmem_req_o     (dmem_req),
        .dmem_we_o      (dmem_we),
        .dmem_addr_o    (dmem_addr),
        .dmem_be_o      (dmem_be),
        .dmem_wdata_o   (dmem_wdata),
        .dmem_rdata_i   (dmem_rdata),
        .dmem_ack_i     (dmem_ack),
        .wb_we_o        (wb_we),
        .wb_reg_data_o  (wb_reg_data),
        .wb_reg_addr_o  (wb_reg_addr),
        .wb_reg_write_o (wb_reg_write),
        .misalign_exc_o (misalign_exc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    task automatic set_word(input int idx, input logic [31:0] w);
        mem_words[idx] = w;
        for (int b = 0; b < 4; b++) ref_bytes[idx*4 + b] = w[8*b +: 8];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, dmem_req, 0);
        check({tag, "_dwe"}, dmem_we, 0);
        check({tag, "_daddr"}, dmem_addr, 0);
        check({tag, "_be"}, dmem_be, 0);
        check({tag, "_wdata"}, dmem_wdata, 0);
        check({tag, "_wbwe"}, wb_we, 0);
        check({tag, "_wbdata"}, wb_reg_data, 0);
        check({tag, "_wbaddr"}, wb_reg_addr, 0);
        check({tag, "_wbwr"}, wb_reg_write, 0);
        check({tag, "_exc"}, misalign_exc, 0);
        check({tag, "_ready"}, ex_ready, 1);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] ra,
                         input logic rw);
        ex_valid = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
        alu_result = addr; store_data = sd; reg_addr = ra; reg_write = rw;
    endtask

    // One instruction from accept to writeback; called with time at #1 after a rising edge.
    task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] ra,
                         input logic rw, input int lat);
        int          n;
        logic [31:0] ea, exp_wd, val;
        logic [3:0]  exp_be;
        bit          mis;
        n   = size_bytes(sz);
        mis = (addr % n) != 0;
        ea  = addr - (addr % n);
        check("ready_before", ex_ready, 1);
        drive(rd, wr, sz, uns, addr, sd, ra, rw);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        if (!(rd || wr)) begin
            check("alu_wbwe", wb_we, 1);
            check("alu_data", wb_reg_data, addr);
            check("alu_raddr", wb_reg_addr, ra);
            check("alu_rwr", wb_reg_write, rw);
            check("alu_noreq", dmem_req, 0);
            @(posedge clk); #1;
            check("alu_pulse", wb_we, 0);
            check("alu_hold", wb_reg_data, addr);
            return;
        end
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        if (mis) begin
            check("mis_exc", misalign_exc, 1);
            check("mis_wbwe", wb_we, 1);
            check("mis_wbwr", wb_reg_write, 0);
            check("mis_noreq", dmem_req, 0);
            check("mis_ready", ex_ready, 1);
            @(posedge clk); #1;
            check("mis_exc_pulse", misalign_exc, 0);
            check("mis_wb_pulse", wb_we, 0);
            return;
        end
`endif
        exp_be = '0;
        exp_wd = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= int'(ea % 4) && i < int'(ea % 4) + n) exp_be[i] = 1'b1;
            exp_wd[8*i +: 8] = 8'((sd >> (8 * (i % n))) & 32'hFF);
        end
        for (int c = 0; c <= lat; c++) begin
            check("mem_req", dmem_req, 1);
            check("mem_addr", dmem_addr, ea & 32'hFFFF_FFFC);
            check("mem_be", dmem_be, exp_be);
            check("mem_we", dmem_we, wr && !rd);
            if (wr && !rd) check("mem_wdata", dmem_wdata, exp_wd);
            check("mem_ready_lo", ex_ready, 0);
            check("mem_no_wb", wb_we, 0);
            if (c < lat) begin
                @(posedge clk); #1;
            end
        end
        dmem_rdata = mem_words[ea[7:2]];
        dmem_ack   = 1'b1;
        if (wr && !rd)
            for (int b = 0; b < 4; b++)
                if (dmem_be[b]) mem_words[ea[7:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
        @(posedge clk); #1;
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        check("ack_wbwe", wb_we, 1);
        check("ack_req_lo", dmem_req, 0);
        check("ack_ready", ex_ready, 1);
        check("ack_raddr", wb_reg_addr, ra);
        if (rd) begin
            val = '0;
            for (int k = 0; k < n; k++) val |= 32'(ref_bytes[8'(ea + k)]) << (8 * k);
            if (!uns && n == 1 && val[7])  val |= 32'hFFFF_FF00;
            if (!uns && n == 2 && val[15]) val |= 32'hFFFF_0000;
            check("ld_data", wb_reg_data, val);
            check("ld_rwr", wb_reg_write, rw);
        end else begin
            for (int k = 0; k < n; k++) ref_bytes[8'(ea + k)] = 8'((sd >> (8 * k)) & 32'hFF);
            check("st_data", wb_reg_data, 0);
            check("st_rwr", wb_reg_write, 0);
        end
        @(posedge clk); #1;
        check("mem_wb_pulse", wb_we, 0);
    endtask

    initial begin
        logic [31:0] b2b_data [4];
        logic [4:0]  b2b_addr [4];
        for (int w = 0; w < 64; w++) set_word(w, $urandom);

        #1;
        check_all_zero("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(0, 0, 2'b10, 0, 32'h1234_5678, 32'h0, 5'd5, 1, 0);
        set_word(0, 32'h80FF_0011);
        do_op(1, 0, 2'b00, 0, 32'h0000_1003, 32'h0, 5'd7, 1, 3);
        check("tp_lb_value", wb_reg_data, 32'hFFFF_FF80);
        do_op(0, 1, 2'b01, 0, 32'h0000_2002, 32'hAAAA_BEEF, 5'd0, 0, 0);
        do_op(1, 0, 2'b10, 0, 32'h0000_3001, 32'h0, 5'd9, 1, 1);

        // Reset during WAIT, then a stray ack after release.
        drive(1, 0, 2'b10, 0, 32'h0000_1010, 32'h0, 5'd3, 1);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        check("rw_req", dmem_req, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("rw");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        check("late_ack_wbwe", wb_we, 0);
        check("late_ack_req", dmem_req, 0);
        @(posedge clk); #1;
        check("late_ack_wbwe2", wb_we, 0);

        for (int i = 0; i < 4; i++) begin
            b2b_data[i] = $urandom;
            b2b_addr[i] = 5'($urandom_range(1, 31));
            drive(0, 0, 2'b10, 0, b2b_data[i], 32'h0, b2b_addr[i], 1);
            @(posedge clk); #1;
            check("b2b_wbwe", wb_we, 1);
            check("b2b_data", wb_reg_data, b2b_data[i]);
            check("b2b_raddr", wb_reg_addr, b2b_addr[i]);
            check("b2b_ready", ex_ready, 1);
        end
        ex_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_end", wb_we, 0);

        for (int t = 0; t < 200; t++) begin
            int          kind;
            logic [31:0] addr;
            kind = int'($urandom_range(0, 3));
            addr = 32'h0000_1000 + $urandom_range(0, 255);
            do_op(kind == 1 || kind == 3, kind == 2 || kind == 3, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), (kind == 0) ? $urandom : addr, $urandom,
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
